axis_uart_tx: RTL and testbench
===============================

Name: axis_uart_tx

Overview:
- AXI Stream sink that serializes each accepted byte onto an asynchronous UART TX line: 8N1 by default, with parity and stop-bit count set by parameter.
- It is the consuming end of an axis_interface stream, for example a FIFO Source output or an AXIS router destination.
- It is the transmit counterpart to the UART receive path that produces AXIS beats.

Parameters:
- CLK_FREQ_HZ, 100_000_000, frequency of clk in Hz.
- BAUD_RATE, 115_200, line bit rate.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- Derived localparam CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, integer-truncated.
- Elaboration $fatal if CLKS_PER_BIT < 2, PARITY > 2, or STOP_BITS is not 1 or 2.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- s_axis  axis_interface.Sink  DATA_WIDTH=8  byte stream in; tready driven by this block. tid, tdest, tuser and tlast are ignored.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line (any state except IDLE).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: uart_tx=1, s_axis.tready=0, busy=0, state=IDLE, counters=0.
- tready register:
  - Set to 1 on the first rising edge after reset deasserts.
  - Thereafter equals (state==IDLE), registered.
- Handshake:
  - A beat is accepted on an edge where tvalid && tready.
  - tvalid may assert independently of tready; the block never depends on tvalid deasserting.
- Null beats: an accepted beat with tkeep[0]==0 is discarded. The state stays IDLE, tready stays 1 and no line activity occurs.
- Valid beats: an accepted beat with tkeep[0]==1 latches tdata into the shift register. The state moves to START and tready=0 on the same edge.
- FSM states and transitions (each bit lasts exactly CLKS_PER_BIT cycles):
  - IDLE: uart_tx=1.
  - START: uart_tx=0.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - PARITY: only entered if PARITY != 0. Odd mode sends ~^data; even mode sends ^data.
  - STOP: uart_tx=1 for STOP_BITS bit periods, then IDLE.
- uart_tx is registered and glitch-free, driven directly from a flop.
- Latency: handshake at edge N gives uart_tx=0 from edge N+1.
- Frame length: F = (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back throughput:
  - After the final stop cycle the state returns to IDLE with tready=1.
  - A beat held valid is accepted on that cycle.
  - Start bits of consecutive frames are therefore F+1 cycles apart, i.e. stop time is extended by one clk.
- Bit timer: counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. It wraps to 0 on each bit boundary and is cleared on entry to START.
- Reset mid-frame: the frame is abandoned immediately (async), uart_tx=1 and tready=0. The next frame after release is transmitted in full; no partial-state carry-over.
- Input stability: tdata changes while tready=0 have no effect.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t with values IDLE, START, DATA, PARITY, STOP.
  - Parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - Function clks_per_bit(clk_hz, baud).
- Sub-module uart_bit_timer(clk, reset, clear, tick): pulses tick on the last cycle of each bit period. It is reusable by the RX path.

Test Plan:
All scenarios use CLK_FREQ_HZ=1_000_000 and BAUD_RATE=100_000, so CLKS_PER_BIT=10.
1. Reset: hold reset with tvalid=1 -> uart_tx=1 and tready=0 throughout. tready=1 on the first edge after release; the beat is accepted on the following edge.
2. 0x55, PARITY=0, STOP_BITS=1 -> line reads 0,1,0,1,0,1,0,1,0,1, each bit exactly 10 cycles. tready is low for 100 cycles, busy is high for 100 cycles, and the line is idle high afterwards.
3. Parity on 0x07 -> even mode gives a parity bit of 1, odd mode gives 0. The frame is 110 cycles; with STOP_BITS=2 it is 120 cycles.
4. 0xA5 then 0x3C with tvalid held high -> the two start-bit falling edges are 101 cycles apart and both bytes are decoded correctly by the bench UART monitor.
5. Beat 0xFF with tkeep=0, then 0x01 with tkeep=1 -> the first beat is accepted with no line activity and tready stays 1. The second is transmitted as 0,1,0,0,0,0,0,0,0,1.
6. Reset asserted during DATA bit 3 of 0xF0 -> uart_tx=1 in the same cycle, with no clock edge needed. After release, 0x81 is transmitted with correct framing and no residual bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity mode codes and the
// bit-period helper used by both the TX and RX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per line bit, integer-truncated.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/axis_interface.sv
// AXI Stream bundle shared by producers (Source) and consumers (Sink).
interface axis_interface #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport Source (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport Sink (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter. tick marks the last clock of each bit;
// clear holds the count at zero so the next period starts aligned.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  // Count 0..CLKS_PER_BIT-1, wrapping on each bit boundary.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI Stream byte sink that serializes each accepted byte as a UART frame:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module axis_uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic        clk,
  input  logic        reset,
  axis_interface.Sink s_axis,
  output logic        uart_tx,
  output logic        busy
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "axis_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
    $fatal(1, "axis_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "axis_uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t state;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [2:0]     bit_idx;
  logic           stop_idx;
  logic           tready_q;
  logic           line_bit;
  logic           tick;
  logic           accept;

  // Sideband fields carry no meaning for a byte-wide serial line.
  logic unused_fields;
  assign unused_fields = ^{s_axis.tlast, s_axis.tid, s_axis.tdest, s_axis.tuser};

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid && tready_q;

  // Timer is held at zero while idle, so START always gets a full period.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  // Line level implied by the current state; registered into uart_tx below.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:            line_bit = 1'b0;
      DATA:             line_bit = shreg[0];
      uart_pkg::PARITY: line_bit = par_bit;
      default:          line_bit = 1'b1;
    endcase
  end

  // Frame sequencer with registered line, ready and busy outputs.
  // NOTE: the shift register and parity flop are reset along with the
  // control state, so a frame cut short by reset leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tready_q <= 1'b0;
      busy     <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= line_bit;
      case (state)
        IDLE: begin
          tready_q <= 1'b1;
          // Beats with tkeep[0]==0 are consumed without touching the line.
          if (accept && s_axis.tkeep[0]) begin
            shreg    <= s_axis.tdata;
            par_bit  <= (PARITY == PARITY_ODD) ? ~^s_axis.tdata : ^s_axis.tdata;
            state    <= START;
            tready_q <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              state    <= (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            state    <= STOP;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state    <= IDLE;
              tready_q <= 1'b1;
              busy     <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tready_q <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx at 10 clocks per bit. One 8N1 instance
// covers handshake, framing, throughput, null beats and reset; three more
// instances cover odd, even and even/2-stop framing.
module tb_axis_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic prst = 1'b0;
  int   cyc  = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  // Cycle stamp for start-bit spacing.
  always @(posedge clk) cyc <= cyc + 1;

  axis_interface #(.DATA_WIDTH(8)) ax    ();
  axis_interface #(.DATA_WIDTH(8)) ax_o  ();
  axis_interface #(.DATA_WIDTH(8)) ax_e  ();
  axis_interface #(.DATA_WIDTH(8)) ax_e2 ();

  logic tx0, tx1, tx2, tx3;
  logic bz0, bz1, bz2, bz3;
  wire [3:0] tx_v   = {tx3, tx2, tx1, tx0};
  wire [3:0] busy_v = {bz3, bz2, bz1, bz0};
  wire [3:0] rdy_v  = {ax_e2.tready, ax_e.tready, ax_o.tready, ax.tready};

  axis_uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset(rst), .s_axis(ax), .uart_tx(tx0), .busy(bz0));
  axis_uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(prst), .s_axis(ax_o), .uart_tx(tx1), .busy(bz1));
  axis_uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(prst), .s_axis(ax_e), .uart_tx(tx2), .busy(bz2));
  axis_uart_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(2), .STOP_BITS(2)) u_even2 (
    .clk(clk), .reset(prst), .s_axis(ax_e2), .uart_tx(tx3), .busy(bz3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the first negedge where the selected line is low.
  task automatic wait_low(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_v[idx] === 1'b0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Returns at the first negedge where the selected tready is high.
  task automatic wait_ready(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rdy_v[idx] === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts negedges while busy is high (sel_busy) or tready is low.
  task automatic count_while(input int idx, input bit sel_busy, output int n);
    n = 0;
    while (n < 1000 && (sel_busy ? (busy_v[idx] === 1'b1) : (rdy_v[idx] === 1'b0))) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Cycle-exact frame check: each bit must hold for exactly CPB samples.
  task automatic check_frame(input string tag, input int idx, input logic [11:0] bits,
                             input int nbits);
    bit ok;
    int cnt;
    wait_low(idx, ok);
    check({tag, "_start_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    for (int b = 0; b < nbits; b++) begin
      cnt = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_v[idx] === bits[b]) cnt++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(cnt), 32'(CPB));
    end
    check({tag, "_idle"}, 32'(tx_v[idx]), 32'd1);
  endtask

  // Mid-bit sampling receiver, as a far-end UART would see the line.
  task automatic rx_byte(input int idx, output logic [7:0] d, output int t0,
                         output bit ok, output bit stop_ok);
    d = '0;
    t0 = 0;
    stop_ok = 1'b0;
    wait_low(idx, ok);
    if (!ok) return;
    t0 = cyc;
    repeat (CPB / 2 - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = tx_v[idx];
    end
    repeat (CPB) @(negedge clk);
    stop_ok = (tx_v[idx] === 1'b1);
  endtask

  task automatic send_main(input logic [7:0] d, input logic k);
    bit ok;
    ax.tdata  = d;
    ax.tkeep  = k;
    ax.tvalid = 1'b1;
    wait_ready(0, ok);
    check("send_ready", 32'(ok), 32'd1);
    @(negedge clk);
    ax.tvalid = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d1, d2;
    int  t1, t2, nr, nb, n1, n2, n3;
    bit  ok, ok1, ok2, s1, s2;

    ax.tdata = '0;    ax.tkeep = '0;    ax.tvalid = 1'b0;    ax.tlast = 1'b0;
    ax.tid = '0;      ax.tdest = '0;    ax.tuser = '0;
    ax_o.tdata = '0;  ax_o.tkeep = '0;  ax_o.tvalid = 1'b0;  ax_o.tlast = 1'b0;
    ax_o.tid = '0;    ax_o.tdest = '0;  ax_o.tuser = '0;
    ax_e.tdata = '0;  ax_e.tkeep = '0;  ax_e.tvalid = 1'b0;  ax_e.tlast = 1'b0;
    ax_e.tid = '0;    ax_e.tdest = '0;  ax_e.tuser = '0;
    ax_e2.tdata = '0; ax_e2.tkeep = '0; ax_e2.tvalid = 1'b0; ax_e2.tlast = 1'b0;
    ax_e2.tid = '0;   ax_e2.tdest = '0; ax_e2.tuser = '0;

    #1;
    rst  = 1'b1;
    prst = 1'b1;

    // 1: reset held with a valid beat pending.
    ax.tdata  = 8'h55;
    ax.tkeep  = 1'b1;
    ax.tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", 32'(tx0), 32'd1);
      check("rst_tready", 32'(ax.tready), 32'd0);
      check("rst_busy", 32'(bz0), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rel_tready", 32'(ax.tready), 32'd1);
    check("rel_tx", 32'(tx0), 32'd1);
    @(negedge clk);
    check("acc_tready", 32'(ax.tready), 32'd0);
    check("acc_busy", 32'(bz0), 32'd1);
    check("acc_tx_latency", 32'(tx0), 32'd1);
    ax.tvalid = 1'b0;
    ax.tdata  = 8'hAA;

    // 2: 0x55 in 8N1, exact bit widths and 100-cycle ready/busy windows.
    fork
      check_frame("f55", 0, {2'b11, 1'b1, 8'h55, 1'b0}, 10);
      count_while(0, 1'b0, nr);
      count_while(0, 1'b1, nb);
    join
    check("f55_tready_low", 32'(nr), 32'd100);
    check("f55_busy_high", 32'(nb), 32'd100);

    // 4: back-to-back with tvalid held; tdata swapped while tready is low.
    repeat (5) @(negedge clk);
    fork
      begin
        ax.tdata  = 8'hA5;
        ax.tkeep  = 1'b1;
        ax.tvalid = 1'b1;
        wait_ready(0, ok);
        check("b2b_ready1", 32'(ok), 32'd1);
        @(negedge clk);
        ax.tdata = 8'h3C;
        wait_ready(0, ok);
        check("b2b_ready2", 32'(ok), 32'd1);
        @(negedge clk);
        ax.tvalid = 1'b0;
      end
      begin
        rx_byte(0, d1, t1, ok1, s1);
        rx_byte(0, d2, t2, ok2, s2);
      end
    join
    check("b2b_seen1", 32'(ok1), 32'd1);
    check("b2b_seen2", 32'(ok2), 32'd1);
    check("b2b_byte1", 32'(d1), 32'hA5);
    check("b2b_byte2", 32'(d2), 32'h3C);
    check("b2b_stop1", 32'(s1), 32'd1);
    check("b2b_stop2", 32'(s2), 32'd1);
    check("b2b_spacing", 32'(t2 - t1), 32'd101);

    // 5: null beats are swallowed, then 0x01 goes out.
    repeat (20) @(negedge clk);
    ax.tdata  = 8'hFF;
    ax.tkeep  = 1'b0;
    ax.tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("null_tready", 32'(ax.tready), 32'd1);
      check("null_tx", 32'(tx0), 32'd1);
      check("null_busy", 32'(bz0), 32'd0);
    end
    ax.tdata = 8'h01;
    ax.tkeep = 1'b1;
    @(negedge clk);
    ax.tvalid = 1'b0;
    check_frame("f01", 0, {2'b11, 1'b1, 8'h01, 1'b0}, 10);

    // 6: asynchronous reset in the middle of data bit 3 of 0xF0.
    repeat (5) @(negedge clk);
    send_main(8'hF0, 1'b1);
    wait_low(0, ok);
    check("f0_start_seen", 32'(ok), 32'd1);
    repeat (CPB * 4 + 5) @(negedge clk);
    check("f0_bit3_low", 32'(tx0), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx0), 32'd1);
    check("async_rst_tready", 32'(ax.tready), 32'd0);
    check("async_rst_busy", 32'(bz0), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_tx", 32'(tx0), 32'd1);
    rst = 1'b0;
    send_main(8'h81, 1'b1);
    check_frame("f81", 0, {2'b11, 1'b1, 8'h81, 1'b0}, 10);

    // 3: 0x07 with odd, even, and even + two stop bits.
    prst = 1'b0;
    repeat (2) @(negedge clk);
    ax_o.tdata = 8'h07;  ax_o.tkeep = 1'b1;  ax_o.tvalid = 1'b1;
    ax_e.tdata = 8'h07;  ax_e.tkeep = 1'b1;  ax_e.tvalid = 1'b1;
    ax_e2.tdata = 8'h07; ax_e2.tkeep = 1'b1; ax_e2.tvalid = 1'b1;
    @(negedge clk);
    ax_o.tvalid  = 1'b0;
    ax_e.tvalid  = 1'b0;
    ax_e2.tvalid = 1'b0;
    check("par_acc_odd", 32'(ax_o.tready), 32'd0);
    check("par_acc_even", 32'(ax_e.tready), 32'd0);
    fork
      check_frame("odd07", 1, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      check_frame("even07", 2, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      check_frame("even07s2", 3, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12);
      count_while(1, 1'b1, n1);
      count_while(2, 1'b1, n2);
      count_while(3, 1'b1, n3);
    join
    check("odd_frame_len", 32'(n1), 32'd110);
    check("even_frame_len", 32'(n2), 32'd110);
    check("even_s2_frame_len", 32'(n3), 32'd120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
